// File: rtl/debug_dump_if.sv
// ---------------------------------------------------------------------------
// debug_dump_if -- host-side byte links of the debug_dump block.
//
// Signals:
//   rx_data  [7:0] command byte from the UART receiver
//   rx_valid       one-cycle strobe, rx_data valid this cycle
//   tx_data  [7:0] frame byte toward the UART transmitter
//   tx_valid       tx_data is valid
//   tx_ready       transmitter accepts tx_data this cycle
//
// Handshake (tx side): a byte moves on every rising edge where
// tx_valid & tx_ready are both high. Once tx_valid is raised it stays high,
// and tx_data stays stable, until that transfer happens.
//
// Modports:
//   master : host/UART side (drives rx_*, tx_ready)
//   slave  : debug_dump side (drives tx_data, tx_valid)
// ---------------------------------------------------------------------------
interface debug_dump_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
   modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/debug_dump.sv
// ---------------------------------------------------------------------------
// debug_dump -- host debug companion of the pipeline.
//
// Executes single-byte host commands (step / run-to-halt / dump) and streams
// a framed snapshot of the pipeline observation buses over a byte handshake.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   bus (slave)       rx_data/rx_valid commands in, tx_data/tx_valid/tx_ready out
//   pc, instruccion, if_id, id_ex, ex_m, m_wb, registros
//                     pipeline observation buses (read directly while frozen)
//   pipe_enable       pipeline enable
//   busy              high in every state except IDLE
//   dbg_state [1:0]   current FSM state (IDLE=0, RUN=1, STEP=2, SEND=3)
//
// Optional feature macro: DEBUG_CYCLE_COUNT_EN
//   When defined, a 32-bit count of enabled pipeline cycles is inserted
//   MSB-first right after the sync byte (181-byte frame instead of 177).
// ---------------------------------------------------------------------------
module debug_dump (
   input  logic            clk,
   input  logic            rst,
   debug_dump_if.slave     bus,
   input  logic [7:0]      pc,
   input  logic [31:0]     instruccion,
   input  logic [39:0]     if_id,
   input  logic [143:0]    id_ex,
   input  logic [79:0]     ex_m,
   input  logic [79:0]     m_wb,
   input  logic [1023:0]   registros,
   output logic            pipe_enable,
   output logic            busy,
   output logic [1:0]      dbg_state
);

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [7:0]  CMD_STEP  = 8'h73;
   localparam logic [7:0]  CMD_RUN   = 8'h63;
   localparam logic [7:0]  CMD_DUMP  = 8'h64;
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      SEND = 2'd3
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] byte_idx;
   logic       tx_fire;
   logic       last_byte;

`ifdef DEBUG_CYCLE_COUNT_EN
   localparam int FRAME_BYTES = 181;
   localparam int FRAME_BITS  = FRAME_BYTES * 8;

   logic [31:0] cycle_count;

   // Free-running count of enabled pipeline cycles; only rst clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_count <= 32'd0;
      end else if (pipe_enable) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end

   logic [FRAME_BITS-1:0] frame;
   assign frame = {SYNC_BYTE, cycle_count, pc, instruccion, if_id, id_ex,
                   ex_m, m_wb, registros};
`else
   localparam int FRAME_BYTES = 177;
   localparam int FRAME_BITS  = FRAME_BYTES * 8;

   logic [FRAME_BITS-1:0] frame;
   assign frame = {SYNC_BYTE, pc, instruccion, if_id, id_ex, ex_m, m_wb,
                   registros};
`endif

   // Byte 0 of the frame sits in the top 8 bits, so select downward from
   // the MSB. The pipeline is frozen while sending, so no snapshot is kept.
   logic [10:0] bit_top;
   assign bit_top = 11'(FRAME_BITS - 1) - {byte_idx, 3'b000};

   assign tx_fire   = bus.tx_valid & bus.tx_ready;
   assign last_byte = (byte_idx == 8'(FRAME_BYTES - 1));

   assign bus.tx_valid = (state == SEND);
   assign bus.tx_data  = (state == SEND) ? frame[bit_top -: 8] : 8'h00;
   assign busy         = (state != IDLE);
   assign dbg_state    = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Outside SEND the index is held at 0, so every frame starts at the sync
   // byte; it wraps back to 0 when the last byte is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx <= 8'd0;
      end else if (state != SEND) begin
         byte_idx <= 8'd0;
      end else if (tx_fire) begin
         byte_idx <= last_byte ? 8'd0 : byte_idx + 8'd1;
      end
   end

   always_comb begin
      state_next  = state;
      pipe_enable = 1'b0;
      case (state)
         IDLE: begin
            if (bus.rx_valid) begin
               case (bus.rx_data)
                  CMD_STEP: state_next = STEP;
                  CMD_RUN:  state_next = RUN;
                  CMD_DUMP: state_next = SEND;
                  default:  state_next = IDLE;
               endcase
            end
         end
         STEP: begin
            pipe_enable = 1'b1;
            state_next  = SEND;
         end
         RUN: begin
            // The halt cycle itself is still an enabled cycle.
            pipe_enable = 1'b1;
            if (instruccion == HALT_WORD) begin
               state_next = SEND;
            end
         end
         SEND: begin
            if (tx_fire && last_byte) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: doc/debug_dump.md
# debug_dump

Debug/host-side companion of the pipeline top level. It consumes the pipeline's observation buses (`pc`, `instruccion`, `if_id`, `id_ex`, `ex_m`, `m_wb`, `registros`) and produces the pipeline `enable`. It executes single-byte host commands (step, run-to-halt, dump) received from a UART receiver. It serialises a framed snapshot of all observation buses to a UART transmitter through a valid/ready byte handshake.

## Interface
- `HALT_WORD`, 32'hFFFF_FFFF: fetched instruction word that ends run mode.
- `CMD_STEP`, 8'h73: advance the pipeline one cycle, then dump.
- `CMD_RUN`, 8'h63: run until halt, then dump.
- `CMD_DUMP`, 8'h64: dump without advancing.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_data` in 8: command byte from the UART receiver.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle.
- `tx_data` out 8: byte to the UART transmitter.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: transmitter accepts the byte this cycle.
- `pipe_enable` out 1: drives the pipeline `enable`.
- `busy` out 1: high in every state except IDLE.
- `pc` in 8, `instruccion` in 32, `if_id` in 40, `id_ex` in 144, `ex_m` in 80, `m_wb` in 80, `registros` in 1024: pipeline observation buses.

## Operation
- States: IDLE, RUN, STEP, SEND.
- IDLE:
  - `rx_valid` with `CMD_STEP` goes to STEP.
  - `CMD_RUN` goes to RUN.
  - `CMD_DUMP` goes to SEND.
  - Any other byte is ignored.
- STEP: `pipe_enable`=1 for exactly one cycle, then SEND.
- RUN: `pipe_enable`=1 every cycle. On a cycle with `instruccion`==`HALT_WORD`, go to SEND. `pipe_enable` is 0 from the next cycle on.
- SEND emits the frame MSB-byte-first per bus, in this order:
  1. `SYNC_BYTE`
  2. `pc` (1 byte)
  3. `instruccion` (4)
  4. `if_id` (5)
  5. `id_ex` (18)
  6. `ex_m` (10)
  7. `m_wb` (10)
  8. `registros` (128; byte 0 = bits [1023:1016])
- Frame length is 177 bytes. After the last byte is accepted, return to IDLE.
- Data are taken directly from the buses through a byte-index mux. The pipeline is frozen (`pipe_enable`=0) throughout SEND, so no snapshot register is needed.
- `rx_valid` is ignored outside IDLE, including a command received during RUN.
- The byte index is an 8-bit counter, cleared on entry to SEND. It increments only on a cycle with `tx_valid`&`tx_ready`.

## Timing
- Reset values:
  - `pipe_enable`=0, `tx_valid`=0, `tx_data`=8'h00, `busy`=0.
  - State IDLE, byte index 0.
- Command latency: the cycle after `rx_valid`, the state has changed and `busy`=1.
- STEP: `pipe_enable` is high on exactly one rising edge. `tx_valid` rises on the following cycle.
- Handshake:
  - A byte is transferred on a cycle with `tx_valid`&`tx_ready`.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` is stable and `tx_valid` stays high.
  - With `tx_ready` tied high, a 177-byte frame takes 177 consecutive cycles.
- `tx_valid` drops on the cycle after the last byte is accepted. `busy` drops on that same cycle.
- Halt in RUN: if `instruccion`==`HALT_WORD` on the first RUN cycle, exactly one enable cycle occurs.
- `rst` mid-frame: everything returns to reset values immediately. No partial-frame resume; the next frame restarts at `SYNC_BYTE`.

## Configuration
- `DEBUG_CYCLE_COUNT_EN` defined:
  - Adds a 32-bit counter that increments on every cycle with `pipe_enable`=1. It wraps at 2^32 and is cleared only by `rst`.
  - The counter is sent MSB-first immediately after `SYNC_BYTE`, giving a 181-byte frame.
- Undefined: no counter, 177-byte frame.

## Test plan
- Reset, `pc`=8'h12, `instruccion`=32'hDEADBEEF, `CMD_DUMP`, `tx_ready`=1: 177 bytes, starting A5,12,DE,AD,BE,EF. `pipe_enable` is never 1. `busy` clears after the final byte.
- `CMD_STEP`: `pipe_enable` is high exactly one cycle, then a full frame. `rx_valid`=1 with `CMD_RUN` during SEND is ignored: no extra enable cycles.
- `CMD_RUN`, bench drives `instruccion`=`HALT_WORD` on the 5th RUN cycle: exactly 5 enable cycles, then a frame whose bytes 2-5 are FF,FF,FF,FF. With `DEBUG_CYCLE_COUNT_EN`, bytes 1-4 are 00,00,00,05.
- Backpressure: hold `tx_ready`=0 for 10 cycles at byte index 40: `tx_valid` stays 1 and `tx_data` is unchanged. The frame completes with no byte lost or duplicated.
- Assert `rst` at byte index 100: outputs reach reset values asynchronously. A subsequent `CMD_DUMP` restarts the frame with A5.
- `rx_data`=8'h41 in IDLE: no state change, `busy`=0, `pipe_enable`=0.
